fp_divsqrt_core: RTL and testbench

- Iterative mantissa divide / square-root engine that sits directly downstream of the input decode stage.
- Consumes the decoded integer mantissas, unbiased exponents, signs and class flags (inf/zero/nan) plus the op code.
- Produces a raw quotient or root with a sticky bit, a result exponent, a sign and result-class flags for the normalise/round stage.
- One result bit is retired per cycle; special operands bypass the iteration.

---
 rtl/fp_divsqrt_core.sv | 240 ++++++++++++++++++++++++
 tb/tb_fp_divsqrt_core.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_divsqrt_core.sv
// fp_divsqrt_core: iterative mantissa divide / square-root engine.
// Retires one quotient or root bit per cycle; special operands bypass the
// iteration and resolve directly to nan/inf/zero result classes.
// Optional build macro FPU_DIVSQRT_EARLY_TERM_EN: a divide whose partial
// remainder reaches zero finishes early, with the remaining quotient bits
// zero-filled. Without it, latency is fixed.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; results from the last op are held
// S_SPECIAL | special operand class; resolve flags, no iteration
// S_ITER    | one result bit per cycle until the counter reaches N-1
// S_DONE    | done pulse for one cycle, results valid
module fp_divsqrt_core #(
    parameter int MAN_W = 53,
    parameter int EXP_W = 12,
    parameter int SP_W  = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [MAN_W-1:0]   manA,
    input  logic [MAN_W-1:0]   manB,
    input  logic [EXP_W-1:0]   expA,
    input  logic [EXP_W-1:0]   expB,
    input  logic               signA,
    input  logic               signB,
    input  logic               infA,
    input  logic               infB,
    input  logic               zeroA,
    input  logic               zeroB,
    input  logic               nanA,
    input  logic               nanB,
    output logic               busy,
    output logic               done,
    output logic [MAN_W+1:0]   quo,
    output logic               sticky,
    output logic [EXP_W:0]     exp_out,
    output logic               sign_out,
    output logic               res_nan,
    output logic               res_inf,
    output logic               res_zero
);

    localparam int QW   = MAN_W + 2;      // quotient / root bits
    localparam int RW   = MAN_W + 3;      // remainder register
    localparam int XW   = RW + 2;         // sqrt trial width
    localparam int RADW = 2 * QW;         // radicand window, consumed 2 bits/cycle

    typedef enum logic [1:0] {S_IDLE, S_SPECIAL, S_ITER, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             dbl_q, dbl_d;
    logic             sqrt_q, sqrt_d;
    logic [MAN_W-1:0] manb_q, manb_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [RADW-1:0]  rad_q, rad_d;
    logic [QW-1:0]    quo_q, quo_d;
    logic             sticky_q, sticky_d;
    logic [EXP_W:0]   exp_q, exp_d;
    logic [EXP_W:0]   pexp_q, pexp_d;
    logic             sign_q, sign_d;
    logic             psign_q, psign_d;
    logic             nan_q, nan_d;
    logic             inf_q, inf_d;
    logic             zero_q, zero_d;
    // captured class flags: {signA, infA, infB, zeroA, zeroB, nanA, nanB}
    logic [6:0]       cls_q, cls_d;

    logic             div_ge, sq_ge, step_bit, is_last, iter_fin, special_in;
    logic [RW-1:0]    div_rem, step_rem, sq_rem;
    logic [XW-1:0]    sq_x, sq_trial;
    logic [QW-1:0]    quo_step;
    logic [5:0]       last_cnt;
    logic [MAN_W-1:0] a_m;
    logic [6:0]       rad_sh;
    logic             sp_sa, sp_ia, sp_ib, sp_za, sp_zb, sp_na, sp_nb;
    logic             sp_nan, sp_inf, sp_zero;

    // one restoring-divide step and one digit-by-digit sqrt step
    assign div_ge   = rem_q >= RW'(manb_q);
    assign div_rem  = div_ge ? (rem_q - RW'(manb_q)) : rem_q;
    assign sq_x     = {rem_q, rad_q[RADW-1 -: 2]};
    assign sq_trial = XW'({quo_q, 2'b01});
    assign sq_ge    = sq_x >= sq_trial;
    assign sq_rem   = RW'(sq_ge ? (sq_x - sq_trial) : sq_x);
    assign step_bit = sqrt_q ? sq_ge : div_ge;
    assign step_rem = sqrt_q ? sq_rem : div_rem;
    assign quo_step = {quo_q[QW-2:0], step_bit};
    assign last_cnt = dbl_q ? 6'(QW - 1) : 6'(SP_W + 1);
    assign is_last  = (cnt_q == last_cnt);

    // operand preparation at accept: single mode only sees the low SP_W bits;
    // the radicand is left-aligned in the window so the first pair is on top
    assign a_m    = op[1] ? manA : MAN_W'(manA[SP_W-1:0]);
    assign rad_sh = (op[1] ? 7'(QW) : 7'(SP_W + 2 + 2 * (MAN_W - SP_W))) + {6'd0, expA[0]};
    assign special_in = op[0] ? (nanA | infA | zeroA | signA)
                              : (nanA | nanB | infA | infB | zeroA | zeroB);

    // special-case resolution, priority nan > inf > zero
    assign {sp_sa, sp_ia, sp_ib, sp_za, sp_zb, sp_na, sp_nb} = cls_q;
    assign sp_nan  = sp_na | (sqrt_q ? (sp_sa & ~sp_za)
                                     : (sp_nb | (sp_za & sp_zb) | (sp_ia & sp_ib)));
    assign sp_inf  = ~sp_nan & (sqrt_q ? (sp_ia & ~sp_sa) : (sp_ia | sp_zb));
    assign sp_zero = ~sp_nan & ~sp_inf & (sqrt_q ? sp_za : (sp_za | sp_ib));

    // next-state and datapath updates
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dbl_d    = dbl_q;
        sqrt_d   = sqrt_q;
        manb_d   = manb_q;
        rem_d    = rem_q;
        rad_d    = rad_q;
        quo_d    = quo_q;
        sticky_d = sticky_q;
        exp_d    = exp_q;
        pexp_d   = pexp_q;
        sign_d   = sign_q;
        psign_d  = psign_q;
        nan_d    = nan_q;
        inf_d    = inf_q;
        zero_d   = zero_q;
        cls_d    = cls_q;
        iter_fin = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    dbl_d    = op[1];
                    sqrt_d   = op[0];
                    manb_d   = op[1] ? manB : MAN_W'(manB[SP_W-1:0]);
                    rem_d    = op[0] ? '0 : RW'(a_m);
                    rad_d    = op[0] ? (RADW'(a_m) << rad_sh) : '0;
                    cnt_d    = '0;
                    quo_d    = '0;
                    sticky_d = 1'b0;
                    exp_d    = '0;
                    sign_d   = 1'b0;
                    nan_d    = 1'b0;
                    inf_d    = 1'b0;
                    zero_d   = 1'b0;
                    pexp_d   = op[0] ? {expA[EXP_W-1], expA[EXP_W-1], expA[EXP_W-1:1]}
                                     : ({expA[EXP_W-1], expA} - {expB[EXP_W-1], expB});
                    psign_d  = op[0] ? signA : (signA ^ signB);
                    cls_d    = {signA, infA, infB, zeroA, zeroB, nanA, nanB};
                    state_d  = special_in ? S_SPECIAL : S_ITER;
                end
            end
            S_SPECIAL: begin
                nan_d   = sp_nan;
                inf_d   = sp_inf;
                zero_d  = sp_zero;
                exp_d   = pexp_q;
                sign_d  = psign_q;
                state_d = S_DONE;
            end
            S_ITER: begin
                quo_d = quo_step;
                rem_d = sqrt_q ? step_rem : (step_rem << 1);
                rad_d = rad_q << 2;
                cnt_d = cnt_q + 6'd1;
                if (is_last) begin
                    iter_fin = 1'b1;
                end
`ifdef FPU_DIVSQRT_EARLY_TERM_EN
                // a zero divide remainder means every remaining quotient bit is 0
                else if (!sqrt_q && (step_rem == '0)) begin
                    iter_fin = 1'b1;
                    quo_d    = quo_step << (last_cnt - cnt_q);
                end
`endif
                if (iter_fin) begin
                    sticky_d = |step_rem;
                    exp_d    = pexp_q;
                    sign_d   = psign_q;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            dbl_q    <= 1'b0;
            sqrt_q   <= 1'b0;
            manb_q   <= '0;
            rem_q    <= '0;
            rad_q    <= '0;
            quo_q    <= '0;
            sticky_q <= 1'b0;
            exp_q    <= '0;
            pexp_q   <= '0;
            sign_q   <= 1'b0;
            psign_q  <= 1'b0;
            nan_q    <= 1'b0;
            inf_q    <= 1'b0;
            zero_q   <= 1'b0;
            cls_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dbl_q    <= dbl_d;
            sqrt_q   <= sqrt_d;
            manb_q   <= manb_d;
            rem_q    <= rem_d;
            rad_q    <= rad_d;
            quo_q    <= quo_d;
            sticky_q <= sticky_d;
            exp_q    <= exp_d;
            pexp_q   <= pexp_d;
            sign_q   <= sign_d;
            psign_q  <= psign_d;
            nan_q    <= nan_d;
            inf_q    <= inf_d;
            zero_q   <= zero_d;
            cls_q    <= cls_d;
        end
    end

    assign busy     = (state_q == S_SPECIAL) || (state_q == S_ITER);
    assign done     = (state_q == S_DONE);
    assign quo      = quo_q;
    assign sticky   = sticky_q;
    assign exp_out  = exp_q;
    assign sign_out = sign_q;
    assign res_nan  = nan_q;
    assign res_inf  = inf_q;
    assign res_zero = zero_q;

endmodule

// File: tb/tb_fp_divsqrt_core.sv
// Directed-vector bench for fp_divsqrt_core with hand-computed expectations.
module tb_fp_divsqrt_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [52:0] manA = '0, manB = '0;
    logic [11:0] expA = '0, expB = '0;
    logic        signA = 0, signB = 0, infA = 0, infB = 0;
    logic        zeroA = 0, zeroB = 0, nanA = 0, nanB = 0;
    logic        busy, done, sticky, sign_out, res_nan, res_inf, res_zero;
    logic [54:0] quo;
    logic [12:0] exp_out;

    int n_vec = 0;
    int n_err = 0;
    int lat;

    fp_divsqrt_core dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .manA(manA), .manB(manB), .expA(expA), .expB(expB),
        .signA(signA), .signB(signB), .infA(infA), .infB(infB),
        .zeroA(zeroA), .zeroB(zeroB), .nanA(nanA), .nanB(nanB),
        .busy(busy), .done(done), .quo(quo), .sticky(sticky),
        .exp_out(exp_out), .sign_out(sign_out),
        .res_nan(res_nan), .res_inf(res_inf), .res_zero(res_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setup(input logic [1:0] o, input logic [52:0] a, input logic [52:0] b,
                         input logic [11:0] ea, input logic [11:0] eb,
                         input logic sa, input logic sb);
        op = o; manA = a; manB = b; expA = ea; expB = eb; signA = sa; signB = sb;
        infA = 0; infB = 0; zeroA = 0; zeroB = 0; nanA = 0; nanB = 0;
    endtask

    // scramble every input after the accept edge: results must not move
    task automatic scramble();
        op = ~op; manA = ~manA; manB = ~manB; expA = ~expA; expB = ~expB;
        signA = ~signA; signB = ~signB; infA = ~infA; infB = ~infB;
        zeroA = ~zeroA; zeroB = ~zeroB; nanA = ~nanA; nanB = ~nanB;
    endtask

    task automatic check_zero_outs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_quo"}, 64'(quo), 0);
        chk({tag, "_flags"}, 64'({sticky, sign_out, res_nan, res_inf, res_zero}), 0);
        chk({tag, "_exp"}, 64'(exp_out), 0);
    endtask

    // accept, then count cycles (cycle 1 = the one after the accept edge) to done
    task automatic launch(input string tag, output int l);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble();
        l = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk({tag, "_busy1"}, 64'(busy), 1);
                chk({tag, "_clrq"}, 64'(quo), 0);
                chk({tag, "_clrf"}, 64'({sticky, sign_out, res_nan, res_inf, res_zero}), 0);
            end
            if (done) begin
                l = c;
                break;
            end
        end
        if (l != 0) begin
            @(negedge clk);
            chk({tag, "_pulse"}, 64'({done, busy}), 0);
        end
    endtask

    task automatic chk_res(input string tag, input logic [63:0] q, input logic st,
                           input logic [12:0] e, input logic sg, input logic [2:0] cls);
        chk({tag, "_quo"}, 64'(quo), q);
        chk({tag, "_sticky"}, 64'(sticky), 64'(st));
        chk({tag, "_exp"}, 64'(exp_out), 64'(e));
        chk({tag, "_sign"}, 64'(sign_out), 64'(sg));
        chk({tag, "_cls"}, 64'({res_nan, res_inf, res_zero}), 64'(cls));
    endtask

    initial begin
        int dones, first;
        setup(2'b00, '0, '0, '0, '0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outs("rst");
        rst_n = 1'b1;

        // reset in the middle of a double divide
        setup(2'b10, 53'h10000000000000, 53'h18000000000000, 12'd10, 12'd3, 0, 0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 20; c++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero_outs("midrst");
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("midrst_nodone", 64'(dones), 0);

        // single divide 1.5/1.0
        setup(2'b00, 53'hC00000, 53'h800000, 12'd5, 12'd2, 0, 1);
        launch("div1", lat);
`ifdef FPU_DIVSQRT_EARLY_TERM_EN
        chk("div1_lat", 64'(lat >= 2 && lat <= 27), 1);
`else
        chk("div1_lat", 64'(lat), 27);
`endif
        chk_res("div1", 64'h3000000, 0, 13'd3, 1, 3'b000);
        repeat (3) @(negedge clk);
        chk("div1_hold", 64'(quo), 64'h3000000);

        // single divide 1.0/1.5
        setup(2'b00, 53'h800000, 53'hC00000, 12'd0, 12'd1, 1, 1);
        launch("div2", lat);
        chk("div2_lat", 64'(lat), 27);
        chk_res("div2", 64'h1555555, 1, 13'h1FFF, 0, 3'b000);

        // double sqrt, odd exponent
        setup(2'b11, 53'h10000000000000, '0, 12'hFFF, '0, 0, 0);
        launch("sqd", lat);
        chk("sqd_lat", 64'(lat), 56);
        chk_res("sqd", 64'h40000000000000, 0, 13'h1FFF, 0, 3'b000);

        // single sqrt, even exponent: sqrt(9*2^46) = 3*2^23
        setup(2'b01, 53'h900000, '0, 12'd4, '0, 0, 0);
        launch("sqs1", lat);
        chk("sqs1_lat", 64'(lat), 27);
        chk_res("sqs1", 64'h1800000, 0, 13'd2, 0, 3'b000);

        // single sqrt, odd exponent: sqrt(2^50) = 2^25
        setup(2'b01, 53'h800000, '0, 12'd3, '0, 0, 0);
        launch("sqs2", lat);
        chk_res("sqs2", 64'h2000000, 0, 13'd1, 0, 3'b000);

        // specials
        setup(2'b00, 53'h800000, 53'h800000, '0, '0, 0, 0);
        nanA = 1;
        launch("nanA", lat);
        chk("nanA_lat", 64'(lat), 2);
        chk("nanA_quo", 64'(quo), 0);
        chk("nanA_cls", 64'({res_nan, res_inf, res_zero}), 3'b100);

        setup(2'b10, 53'h10000000000000, '0, '0, '0, 1, 0);
        zeroB = 1;
        launch("divz", lat);
        chk("divz_lat", 64'(lat), 2);
        chk("divz_cls", 64'({res_nan, res_inf, res_zero}), 3'b010);
        chk("divz_sign", 64'(sign_out), 1);

        setup(2'b01, 53'h800000, '0, '0, '0, 1, 0);
        launch("sqneg", lat);
        chk("sqneg_cls", 64'({res_nan, res_inf, res_zero}), 3'b100);

        setup(2'b00, '0, '0, '0, '0, 0, 0);
        infA = 1; infB = 1;
        launch("infinf", lat);
        chk("infinf_cls", 64'({res_nan, res_inf, res_zero}), 3'b100);

        setup(2'b01, '0, '0, '0, '0, 1, 0);
        zeroA = 1;
        launch("sqm0", lat);
        chk("sqm0_cls", 64'({res_nan, res_inf, res_zero}), 3'b001);
        chk("sqm0_sign", 64'(sign_out), 1);

        // double divide 1.0/1.5 with a start pulse while busy
        setup(2'b10, 53'h10000000000000, 53'h18000000000000, 12'd10, 12'd3, 0, 0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dones = 0;
        first = 0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (c == 10) begin
                start = 1'b1;
                op = 2'b01;
                manA = '0;
            end
            if (c == 11) start = 1'b0;
            if (c == 55) chk("ign_busy55", 64'(busy), 1);
            if (done) begin
                dones++;
                if (first == 0) first = c;
                chk("ign_busy_at_done", 64'(busy), 0);
            end
        end
        chk("ign_ndone", 64'(dones), 1);
        chk("ign_lat", 64'(first), 56);
        chk_res("ign", 64'h2AAAAAAAAAAAAA, 1, 13'd7, 0, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
